// File: rtl/inst_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_cycle_ctrl
// Description : Multi-cycle RV32 sequencer (IDLE/FETCH/DECODE/EXEC/WB/HALT)
//               that owns the PC, IR, retired count and halt/error status.
//               Optional fetch watchdog enabled by CTRL_FETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cycle_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        if_req,
    output logic [31:0] if_addr,
    input  logic        if_rvalid,
    input  logic [31:0] if_rdata,
    output logic [31:0] inst,
    input  logic [1:0]  idu_command,
    output logic        exu_valid,
    input  logic        exu_done,
    input  logic [31:0] next_pc,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] c_CMD_ALU    = 2'b01;
    localparam logic [1:0] c_CMD_EXEC   = 2'b10;
    localparam logic [1:0] c_CMD_EBREAK = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] instret_q, instret_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        halt_q, halt_d;
    logic        err_q, err_d;
    logic        if_req_q, if_req_d;
    logic        exu_valid_q, exu_valid_d;
    logic        rf_wen_q, rf_wen_d;
    logic        w_timeout;

`ifdef CTRL_FETCH_TIMEOUT_EN
    localparam int unsigned c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counter idles at zero outside FETCH, so every FETCH entry starts clean.
    assign w_timeout = (state_q == S_FETCH) && (to_cnt_q == c_TO_W'(TIMEOUT_CYCLES - 1));
    assign to_cnt_d  = (state_q == S_FETCH && !if_rvalid && !w_timeout)
                     ? to_cnt_q + c_TO_W'(1) : '0;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        npc_d     = npc_q;
        instret_d = instret_q;
        cmd_d     = cmd_q;
        halt_d    = halt_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (if_rvalid) begin
                    inst_d  = if_rdata;
                    state_d = S_DECODE;
                end else if (w_timeout) begin
                    halt_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                cmd_d = idu_command;
                case (idu_command)
                    c_CMD_ALU, c_CMD_EXEC: state_d = S_EXEC;
                    c_CMD_EBREAK: begin
                        halt_d  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        halt_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                if (exu_done) begin
                    npc_d = next_pc;
                    // Misaligned target faults before any architectural update.
                    if (next_pc[1:0] != 2'b00) begin
                        halt_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else if (cmd_q == c_CMD_ALU) begin
                        state_d = S_WB;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_d      = npc_q;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if_req_d    = (state_d == S_FETCH);
        rf_wen_d    = (state_d == S_WB);
        exu_valid_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            npc_q       <= 32'd0;
            instret_q   <= 32'd0;
            cmd_q       <= 2'b00;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            if_req_q    <= 1'b0;
            exu_valid_q <= 1'b0;
            rf_wen_q    <= 1'b0;
`ifdef CTRL_FETCH_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            npc_q       <= npc_d;
            instret_q   <= instret_d;
            cmd_q       <= cmd_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
            if_req_q    <= if_req_d;
            exu_valid_q <= exu_valid_d;
            rf_wen_q    <= rf_wen_d;
`ifdef CTRL_FETCH_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign if_req    = if_req_q;
    assign if_addr   = pc_q;
    assign inst      = inst_q;
    assign exu_valid = exu_valid_q;
    assign rf_wen    = rf_wen_q;
    assign pc        = pc_q;
    assign instret   = instret_q;
    assign halt      = halt_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_cycle_ctrl.sv
`default_nettype none
// Testbench for inst_cycle_ctrl: directed steps plus random instruction
// sequences checked against an instruction-level reference model.
module tb_inst_cycle_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TO       = 4;
`ifdef CTRL_FETCH_TIMEOUT_EN
    localparam int MAX_RD  = TO - 1;
    localparam int LONG_RD = TO - 1;
`else
    localparam int MAX_RD  = 6;
    localparam int LONG_RD = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        if_rvalid = 1'b0;
    logic [31:0] if_rdata = 32'd0;
    logic [1:0]  idu_command = 2'b00;
    logic        exu_done = 1'b0;
    logic [31:0] next_pc = 32'd0;
    logic        if_req, exu_valid, rf_wen, halt, err;
    logic [31:0] if_addr, inst, pc, instret;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_instret, m_inst;
    logic        m_halt, m_err;

    always #5 clk = ~clk;

    inst_cycle_ctrl #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .inst        (inst),
        .idu_command (idu_command),
        .exu_valid   (exu_valid),
        .exu_done    (exu_done),
        .next_pc     (next_pc),
        .rf_wen      (rf_wen),
        .pc          (pc),
        .instret     (instret),
        .halt        (halt),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instret = 32'd0;
        m_inst    = 32'd0;
        m_halt    = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"},      pc,      m_pc);
        check({tag, "_instret"}, instret, m_instret);
        check({tag, "_halt"},    {31'd0, halt}, {31'd0, m_halt});
        check({tag, "_err"},     {31'd0, err},  {31'd0, m_err});
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; if_rvalid = 1'b0; exu_done = 1'b0;
        tick();
        model_reset();
        check("rst_if_req",    {31'd0, if_req},    32'd0);
        check("rst_exu_valid", {31'd0, exu_valid}, 32'd0);
        check("rst_rf_wen",    {31'd0, rf_wen},    32'd0);
        check("rst_inst",      inst,               32'd0);
        check_arch("rst");
        rst = 1'b0;
        tick();
        check("idle_if_req", {31'd0, if_req}, 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_if_req", {31'd0, if_req}, 32'd1);
    endtask

    // One instruction from its first FETCH cycle until the next FETCH or HALT.
    task automatic run_instr(input logic [1:0] cmd, input int rd, input int dd,
                             input logic [31:0] npc, input logic [31:0] word);
        int req_c = 0, val_c = 0, wen_c = 0, addr_bad = 0, inst_bad = 0;
        int cyc, k = 0, rv_iter = -1, exp_cyc;
        bit left = 0, in_exec = 0, done_given = 0, ok, fault, retire;
        logic [31:0] inst_after = 32'd0;
        ok     = (cmd == 2'b01) || (cmd == 2'b10);
        fault  = ok && (npc[1:0] != 2'b00);
        retire = ok && !fault;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0 && (halt === 1'b1 || (if_req === 1'b1 && left))) break;
            if (if_req !== 1'b1) left = 1;
            if (in_exec && done_given) in_exec = 0;
            if (if_req === 1'b1) begin
                req_c++;
                if (if_addr !== m_pc) addr_bad++;
                if (inst !== m_inst) inst_bad++;
            end
            if (exu_valid === 1'b1) begin
                val_c++; in_exec = 1; k = 0; done_given = 0;
            end
            if (rf_wen === 1'b1) wen_c++;
            if (rv_iter >= 0 && cyc == rv_iter + 1) inst_after = inst;

            start = 1'($urandom);
            if (if_req === 1'b1 && !left) begin
                if_rvalid = (req_c > rd);
                if (if_rvalid && rv_iter < 0) rv_iter = cyc;
            end else begin
                if_rvalid = 1'($urandom);
            end
            if_rdata    = if_rvalid ? word : $urandom;
            idu_command = (rv_iter >= 0 && cyc == rv_iter + 1) ? cmd : 2'($urandom);
            if (in_exec) begin
                exu_done = (k == dd);
                if (exu_done) done_given = 1;
                else k++;
                next_pc = exu_done ? npc : $urandom;
            end else begin
                exu_done = 1'($urandom);
                next_pc  = $urandom;
            end
            tick();
        end
        start = 1'b0; if_rvalid = 1'b0; exu_done = 1'b0;

        exp_cyc = rd + 2 + (ok ? dd + 1 : 0) + ((retire && cmd == 2'b01) ? 1 : 0);
        m_inst = word;
        if (retire) begin
            m_pc      = npc;
            m_instret = m_instret + 32'd1;
        end else begin
            m_halt = 1'b1;
            m_err  = (cmd != 2'b11);
        end
        check("instr_cycles",  32'(cyc),      32'(exp_cyc));
        check("req_cycles",    32'(req_c),    32'(rd + 1));
        check("valid_pulses",  32'(val_c),    ok ? 32'd1 : 32'd0);
        check("wen_cycles",    32'(wen_c),    (retire && cmd == 2'b01) ? 32'd1 : 32'd0);
        check("addr_unstable", 32'(addr_bad), 32'd0);
        check("inst_early",    32'(inst_bad), 32'd0);
        check("inst_loaded",   inst_after,    word);
        check("end_if_req",    {31'd0, if_req}, {31'd0, retire});
        check_arch("instr");
    endtask

    task automatic check_halted(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            start       = ~i[0];
            if_rvalid   = 1'($urandom);
            exu_done    = 1'($urandom);
            next_pc     = $urandom;
            idu_command = 2'($urandom);
            tick();
            if (if_req !== 1'b0 || exu_valid !== 1'b0 || rf_wen !== 1'b0) bad++;
        end
        start = 1'b0; if_rvalid = 1'b0; exu_done = 1'b0;
        check("halt_quiet", 32'(bad), 32'd0);
        check_arch("halted");
    endtask

    initial begin
        logic [1:0]  cmd;
        logic [31:0] npc;
        int          r;

        model_reset();
        do_reset();
        do_start();
        run_instr(2'b01, 0, 0, 32'h8000_0004, 32'h0050_0093);
        run_instr(2'b10, LONG_RD, 3, 32'h8000_0100, 32'h0000_0063);

        for (int i = 0; i < 40; i++) begin
            r   = int'($urandom_range(0, 9));
            cmd = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            npc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) npc[1:0] = 2'($urandom_range(1, 3));
            run_instr(cmd, int'($urandom_range(0, MAX_RD)), int'($urandom_range(0, 4)),
                      npc, $urandom);
            if (m_halt) begin
                check_halted(3);
                do_reset();
                do_start();
            end
        end

        // Asynchronous reset in the first EXEC cycle.
        do_reset();
        do_start();
        run_instr(2'b10, 0, 0, 32'h1234_5678, 32'h0000_0013);
        if_rvalid = 1'b1; if_rdata = 32'h0000_0033;
        tick();
        if_rvalid = 1'b0; idu_command = 2'b10; exu_done = 1'b0;
        tick();
        check("exec_valid", {31'd0, exu_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("arst_if_req",    {31'd0, if_req},    32'd0);
        check("arst_exu_valid", {31'd0, exu_valid}, 32'd0);
        check("arst_rf_wen",    {31'd0, rf_wen},    32'd0);
        check_arch("arst");
        tick();
        rst = 1'b0;

        do_start();
        run_instr(2'b11, 1, 0, 32'h8000_0008, 32'h0010_0073);
        check_halted(4);
        do_reset();
        do_start();
        run_instr(2'b00, 0, 0, 32'h8000_0008, 32'hFFFF_FFFF);
        check_halted(4);
        do_reset();
        do_start();
        run_instr(2'b01, 0, 0, 32'h8000_0006, 32'h0000_0067);
        check_halted(2);

`ifdef CTRL_FETCH_TIMEOUT_EN
        begin
            int req_c = 0;
            do_reset();
            do_start();
            for (int c = 0; c < 50; c++) begin
                if (halt === 1'b1) break;
                if (if_req === 1'b1) req_c++;
                tick();
            end
            m_halt = 1'b1;
            m_err  = 1'b1;
            check("to_req_cycles", 32'(req_c), 32'(TO));
            check("to_if_req",     {31'd0, if_req}, 32'd0);
            check_arch("to");
            do_reset();
            do_start();
            run_instr(2'b10, TO - 1, 0, 32'h8000_0040, 32'h0000_0013);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
